// File: rtl/uart_receiver.sv
// UART receiver: START, 8 data bits LSB first, optional even parity, STOP; 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to add the even-parity bit and the parity_err strobe.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_clk_en,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int M   = OVERSAMPLE / 2;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SC_LO  = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_MID = SCW'(M);
    localparam logic [SCW-1:0] SC_HI  = SCW'(M + 1);
    localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state;
    logic           sync1;
    logic           rxs;
    logic           prev;
    logic [SCW-1:0] sc;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           s_lo;
    logic           s_mid;
    logic           s_hi;
    logic           cap_hi;
    logic           vote;
    logic           par_err;

    // On the sc=M+1 tick the third capture is the live sample, so the vote can be decided that same tick.
    assign cap_hi  = (sc == SC_HI) ? rxs : s_hi;
    assign vote    = (s_lo & s_mid) | (s_lo & cap_hi) | (s_mid & cap_hi);
    assign rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;
    assign par_err    = ^{shift_reg, par_bit};
    assign parity_err = parity_err_q;
`else
    assign par_err    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            prev      <= 1'b1;
            sc        <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            s_lo      <= 1'b0;
            s_mid     <= 1'b0;
            s_hi      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1     <= rx_line;
            rxs       <= sync1;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rx_clk_en) begin
                // prev tracks the line in every state so a held-low break cannot retrigger on return to IDLE.
                prev <= rxs;
                if (state != IDLE) begin
                    sc <= sc + 1'b1;
                    if (sc == SC_LO)  s_lo  <= rxs;
                    if (sc == SC_MID) s_mid <= rxs;
                    if (sc == SC_HI)  s_hi  <= rxs;
                end
                case (state)
                    IDLE: begin
                        if (prev && !rxs) begin
                            state <= START;
                            sc    <= '0;
                        end
                    end
                    START: begin
                        if (sc == SC_HI && vote) begin
                            state <= IDLE;
                            sc    <= '0;
                        end else if (sc == SC_END) begin
                            state   <= DATA;
                            sc      <= '0;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (sc == SC_END) begin
                            shift_reg <= {vote, shift_reg[7:1]};
                            sc        <= '0;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (sc == SC_END) begin
                            par_bit <= vote;
                            state   <= STOP;
                            sc      <= '0;
                        end
                    end
`endif
                    STOP: begin
                        // Deciding mid-stop leaves half a bit to resynchronise on the next start edge.
                        if (sc == SC_HI) begin
                            state <= IDLE;
                            sc    <= '0;
                            if (!vote) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (par_err) parity_err_q <= 1'b1;
`endif
                            if (vote && !par_err) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sc    <= '0;
                    end
                endcase
            end
        end
    end

endmodule
